hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller: the control end of the ID/EX (and IF/ID, PC) register interface.
- Produces the enable and flush strobes those registers sample: enablePC, enableIF/resetIF, enableID/resetID, enableEX.
- Inputs are decode-stage register indices and execute-stage status.
- Handles load-use stalls (parameterised length), taken-branch flushes and multi-cycle data-memory freezes; keeps a stall-cycle performance counter.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout sets (1..65535).

Ports:
reloj  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
rs_id  in  5  rs of instruction in ID.
rt_id  in  5  rt of instruction in ID.
uses_rt_id  in  1  ID instruction reads rt as a source.
rt_exe  in  5  destination rt of instruction in EXE.
mem_read_exe  in  1  EXE instruction is a load.
branch_taken  in  1  branch resolved taken in EXE this cycle.
mem_busy  in  1  data memory not ready; MEM stage must hold.
enablePC  out  1  PC load enable.
enableIF  out  1  IF/ID load enable.
resetIF  out  1  IF/ID synchronous clear.
enableID  out  1  ID/EX load enable.
resetID  out  1  ID/EX synchronous clear (bubble).
enableEX  out  1  EX/MEM load enable.
mem_timeout  out  1  sticky error: MEM_WAIT exceeded MEM_TIMEOUT.
stall_count  out  16  saturating count of cycles with enablePC=0.

Behaviour:
- Registered state: state {RUN, LOAD_STALL, MEM_WAIT}, 4-bit bubble counter, 16-bit wait counter, mem_timeout, stall_count.
- Strobe outputs are combinational from current state and inputs, so the pipeline registers act in the same edge.
- Default strobes (RUN, no event): all enables 1, resetIF=resetID=0.
- Reset (reset=1):
  - Strobes: all enables 0; resetIF=1, resetID=1.
  - Next edge: state=RUN, counters=0, mem_timeout=0, stall_count=0.
- Hazard term: load_use = mem_read_exe && rt_exe!=0 && (rt_exe==rs_id || (uses_rt_id && rt_exe==rt_id)).
- Event priority, highest first: reset > mem_busy > branch_taken > load_use.
- mem_busy=1, any state:
  - Freeze: enablePC=enableIF=enableID=enableEX=0; no clears.
  - Next state MEM_WAIT; the interrupted state's bubble counter is preserved.
  - Wait counter increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset.
- MEM_WAIT with mem_busy=0:
  - Strobes evaluated as RUN for this cycle.
  - Wait counter cleared.
  - Next state LOAD_STALL if the bubble counter is nonzero, else RUN.
- branch_taken=1 (RUN or LOAD_STALL):
  - resetIF=1, resetID=1, enablePC=1 (target loads), enableEX=1.
  - Aborts any stall: bubble counter cleared, next state RUN.
- load_use in RUN:
  - enablePC=0, enableIF=0, resetID=1, enableEX=1.
  - If LOAD_STALL_CYCLES>1: counter=LOAD_STALL_CYCLES-1, next state LOAD_STALL; else stay RUN.
- LOAD_STALL:
  - Same strobes as load_use.
  - Counter decrements each cycle; when it reaches 0, next state RUN.
  - load_use is not re-evaluated inside LOAD_STALL.
- Simultaneous load_use and branch_taken: branch wins; no bubble counted.
- stall_count: +1 on each non-reset cycle with enablePC=0; saturates at 16'hFFFF.

Test Plan:
- Load-use: mem_read_exe=1, rt_exe=5, rs_id=5, LOAD_STALL_CYCLES=1 -> one cycle of enablePC=0, enableIF=0, resetID=1, then all enables 1; stall_count=1.
- rt_exe=0 with match, or uses_rt_id=0 with rt match only -> no stall; stall_count stays 0.
- LOAD_STALL_CYCLES=3, load-use; branch_taken on 2nd bubble -> that cycle resetIF=resetID=1, enablePC=1; next cycle RUN; stall_count=1.
- mem_busy held 4 cycles during LOAD_STALL (counter=1) -> 4 frozen cycles; one more bubble after release; then RUN; stall_count increments for all frozen and bubble cycles.
- MEM_TIMEOUT=3, mem_busy held 5 cycles -> mem_timeout rises after the 3rd wait cycle and stays 1 after mem_busy drops; cleared only by reset.
- Assert reset mid-LOAD_STALL -> strobes show flush (enables 0, resetIF=resetID=1); next cycle RUN with counters, mem_timeout and stall_count all 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives PC, IF/ID, ID/EX and EX/MEM enable/clear strobes
// for load-use bubbles, taken-branch flushes and data-memory freezes.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic        reloj,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        uses_rt_id,
    input  logic [4:0]  rt_exe,
    input  logic        mem_read_exe,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        enablePC,
    output logic        enableIF,
    output logic        resetIF,
    output logic        enableID,
    output logic        resetID,
    output logic        enableEX,
    output logic        mem_timeout,
    output logic [15:0] stall_count
);

    localparam int unsigned BUB_W = 4;
    localparam int unsigned CNT_W = 16;

    localparam logic [BUB_W-1:0] BUB_INIT   = BUB_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [BUB_W-1:0] BUB_ONE    = BUB_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BUB_W-1:0]  bub_q, bub_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              timeout_d;
    logic              load_use;

    // Load in EXE writes a register the ID instruction reads ($0 never hazards).
    assign load_use = mem_read_exe && (rt_exe != 5'd0) &&
                      ((rt_exe == rs_id) || (uses_rt_id && (rt_exe == rt_id)));

    // Strobes and next state; priority reset > mem_busy > branch > load_use.
    always_comb begin
        enablePC  = 1'b1;
        enableIF  = 1'b1;
        resetIF   = 1'b0;
        enableID  = 1'b1;
        resetID   = 1'b0;
        enableEX  = 1'b1;
        state_d   = state_q;
        bub_d     = bub_q;
        wait_d    = wait_q;
        timeout_d = mem_timeout;

        if (reset) begin
            enablePC = 1'b0;
            enableIF = 1'b0;
            enableID = 1'b0;
            enableEX = 1'b0;
            resetIF  = 1'b1;
            resetID  = 1'b1;
        end else if (mem_busy) begin
            enablePC = 1'b0;
            enableIF = 1'b0;
            enableID = 1'b0;
            enableEX = 1'b0;
            state_d  = MEM_WAIT;
            if (wait_q != CNT_MAX) begin
                wait_d = wait_q + CNT_ONE;
            end
            if (wait_d >= WAIT_LIMIT) begin
                timeout_d = 1'b1;
            end
        end else begin
            wait_d = '0;
            if (branch_taken) begin
                resetIF = 1'b1;
                resetID = 1'b1;
                bub_d   = '0;
                state_d = RUN;
            end else if (state_q == LOAD_STALL) begin
                enablePC = 1'b0;
                enableIF = 1'b0;
                resetID  = 1'b1;
                bub_d    = bub_q - BUB_ONE;
                state_d  = (bub_q == BUB_ONE) ? RUN : LOAD_STALL;
            end else if ((state_q == MEM_WAIT) && (bub_q != '0)) begin
                // Release from a freeze that interrupted a stall: resume the stall next.
                state_d = LOAD_STALL;
                if (load_use) begin
                    enablePC = 1'b0;
                    enableIF = 1'b0;
                    resetID  = 1'b1;
                end
            end else if (load_use) begin
                enablePC = 1'b0;
                enableIF = 1'b0;
                resetID  = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    bub_d   = BUB_INIT;
                    state_d = LOAD_STALL;
                end else begin
                    state_d = RUN;
                end
            end else begin
                state_d = RUN;
            end
        end
    end

    // State, counters and sticky timeout.
    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q     <= RUN;
            bub_q       <= '0;
            wait_q      <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            state_q     <= state_d;
            bub_q       <= bub_d;
            wait_q      <= wait_d;
            mem_timeout <= timeout_d;
            if (!enablePC && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-bubble/long timeout and 3-bubble/short timeout)
// checked every cycle against a bubble-debt model, plus hand-computed literal checks.
module tb_hazard_ctrl;

    localparam int unsigned LSC_A = 1;
    localparam int unsigned MT_A  = 255;
    localparam int unsigned LSC_B = 3;
    localparam int unsigned MT_B  = 3;

    logic        reloj = 1'b0;
    logic        reset;
    logic [4:0]  rs_id, rt_id, rt_exe;
    logic        uses_rt_id, mem_read_exe, branch_taken, mem_busy;

    logic        a_pc, a_if, a_rif, a_id, a_rid, a_ex, a_tmo;
    logic [15:0] a_cnt;
    logic        b_pc, b_if, b_rif, b_id, b_rid, b_ex, b_tmo;
    logic [15:0] b_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;
    bit check_en = 1'b0;

    // Model: outstanding bubbles owed, whether the last cycle was frozen, wait length.
    int m_pending [2] = '{0, 0};
    bit m_in_wait [2] = '{1'b0, 1'b0};
    int m_wait    [2] = '{0, 0};
    bit m_tmo     [2] = '{1'b0, 1'b0};
    int m_stalls  [2] = '{0, 0};
    int m_lsc     [2] = '{LSC_A, LSC_B};
    int m_mt      [2] = '{MT_A, MT_B};

    always #5 reloj = ~reloj;

    hazard_ctrl #(.LOAD_STALL_CYCLES(LSC_A), .MEM_TIMEOUT(MT_A)) dut_a (
        .reloj(reloj), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rt_id(uses_rt_id), .rt_exe(rt_exe), .mem_read_exe(mem_read_exe),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .enablePC(a_pc), .enableIF(a_if), .resetIF(a_rif), .enableID(a_id),
        .resetID(a_rid), .enableEX(a_ex), .mem_timeout(a_tmo), .stall_count(a_cnt)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(LSC_B), .MEM_TIMEOUT(MT_B)) dut_b (
        .reloj(reloj), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rt_id(uses_rt_id), .rt_exe(rt_exe), .mem_read_exe(mem_read_exe),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .enablePC(b_pc), .enableIF(b_if), .resetIF(b_rif), .enableID(b_id),
        .resetID(b_rid), .enableEX(b_ex), .mem_timeout(b_tmo), .stall_count(b_cnt)
    );

    task automatic check_dut(input int k, input logic [5:0] got, input logic tmo,
                             input logic [15:0] cnt);
        string      nm [6] = '{"enablePC", "enableIF", "resetIF", "enableID", "resetID", "enableEX"};
        logic [5:0] exp;
        bit         lu;
        lu = mem_read_exe && (rt_exe != 0) &&
             ((rt_exe == rs_id) || (uses_rt_id && (rt_exe == rt_id)));
        // Bit order {pc, if, rif, id, rid, ex}.
        if (reset)                                        exp = 6'b001010;
        else if (mem_busy)                                exp = 6'b000000;
        else if (branch_taken)                            exp = 6'b111111;
        else if ((m_pending[k] > 0 && !m_in_wait[k]) || lu) exp = 6'b000111;
        else                                              exp = 6'b110101;

        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[5-i] !== exp[5-i]) begin
                n_fail++;
                $display("FAIL model dut%0d %s cycle %0d: got %b expected %b",
                         k, nm[i], cycle, got[5-i], exp[5-i]);
            end
        end
        n_cmp++;
        if (tmo !== m_tmo[k]) begin
            n_fail++;
            $display("FAIL model dut%0d mem_timeout cycle %0d: got %b expected %b",
                     k, cycle, tmo, m_tmo[k]);
        end
        n_cmp++;
        if (cnt !== 16'(m_stalls[k])) begin
            n_fail++;
            $display("FAIL model dut%0d stall_count cycle %0d: got %0d expected %0d",
                     k, cycle, cnt, m_stalls[k]);
        end

        // Advance the model across the coming edge.
        if (reset) begin
            m_pending[k] = 0; m_in_wait[k] = 1'b0; m_wait[k] = 0;
            m_tmo[k] = 1'b0;  m_stalls[k] = 0;
        end else begin
            if (!exp[5] && m_stalls[k] < 65535) m_stalls[k]++;
            if (mem_busy) begin
                m_in_wait[k] = 1'b1;
                if (m_wait[k] < 65535) m_wait[k]++;
                if (m_wait[k] >= m_mt[k]) m_tmo[k] = 1'b1;
            end else begin
                if (branch_taken)                         m_pending[k] = 0;
                else if (m_pending[k] > 0 && !m_in_wait[k]) m_pending[k]--;
                else if (m_pending[k] == 0 && lu)         m_pending[k] = m_lsc[k] - 1;
                m_in_wait[k] = 1'b0;
                m_wait[k]    = 0;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge reloj) begin
        if (check_en) begin
            check_dut(0, {a_pc, a_if, a_rif, a_id, a_rid, a_ex}, a_tmo, a_cnt);
            check_dut(1, {b_pc, b_if, b_rif, b_id, b_rid, b_ex}, b_tmo, b_cnt);
        end
        cycle++;
    end

    task automatic lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        rs_id = 5'd0; rt_id = 5'd0; rt_exe = 5'd0; uses_rt_id = 1'b0;
        mem_read_exe = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic next();
        @(posedge reloj);
        #1;
    endtask

    task automatic load_use_on_rs();
        idle();
        mem_read_exe = 1'b1; rt_exe = 5'd5; rs_id = 5'd5;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        next();
        check_en = 1'b1;
        @(negedge reloj);
        lit("reset_enablePC", a_pc, 0);
        lit("reset_resetIF", a_rif, 1);
        lit("reset_resetID", b_rid, 1);
        lit("reset_stall_count", a_cnt, 0);
        next();
        reset = 1'b0;
        @(negedge reloj);
        lit("run_default_enablePC", a_pc, 1);
        lit("run_default_resetID", a_rid, 0);
        next();

        // Single-bubble load-use on dut_a.
        load_use_on_rs();
        @(negedge reloj);
        lit("lu1_enablePC", a_pc, 0);
        lit("lu1_enableIF", a_if, 0);
        lit("lu1_resetID", a_rid, 1);
        lit("lu1_enableEX", a_ex, 1);
        next();
        idle();
        @(negedge reloj);
        lit("lu1_after_enablePC", a_pc, 1);
        lit("lu1_after_stall_count", a_cnt, 1);
        next(); next(); next();
        lit("lu3_stall_count", b_cnt, 3);

        // Non-hazards: $0 destination, rt match without rt use.
        idle(); mem_read_exe = 1'b1; rt_exe = 5'd0; rs_id = 5'd0;
        @(negedge reloj);
        lit("rt0_no_stall", a_pc, 1);
        next();
        idle(); mem_read_exe = 1'b1; rt_exe = 5'd7; rt_id = 5'd7; rs_id = 5'd3;
        @(negedge reloj);
        lit("no_rt_use_no_stall", a_pc, 1);
        next();
        lit("no_stall_count_held", a_cnt, 1);
        uses_rt_id = 1'b1;
        @(negedge reloj);
        lit("rt_use_stall", a_pc, 0);
        next();
        idle(); next(); next(); next();

        // Branch during the second bubble aborts the 3-cycle stall.
        do_reset();
        load_use_on_rs();
        next();
        idle(); branch_taken = 1'b1;
        @(negedge reloj);
        lit("br_resetIF", b_rif, 1);
        lit("br_resetID", b_rid, 1);
        lit("br_enablePC", b_pc, 1);
        next();
        idle();
        @(negedge reloj);
        lit("br_after_enablePC", b_pc, 1);
        lit("br_after_resetID", b_rid, 0);
        lit("br_after_stall_count", b_cnt, 1);
        next();

        // Freeze during a stall with one bubble still owed.
        do_reset();
        load_use_on_rs();
        next();
        idle();
        next();
        for (int i = 0; i < 4; i++) begin
            mem_busy = 1'b1;
            @(negedge reloj);
            lit("frz_enablePC", b_pc, 0);
            lit("frz_enableEX", b_ex, 0);
            lit("frz_resetID", b_rid, 0);
            next();
        end
        idle();
        @(negedge reloj);
        lit("frz_release_enablePC", b_pc, 1);
        next();
        @(negedge reloj);
        lit("frz_bubble_enablePC", b_pc, 0);
        lit("frz_bubble_resetID", b_rid, 1);
        next();
        @(negedge reloj);
        lit("frz_done_enablePC", b_pc, 1);
        lit("frz_stall_count_b", b_cnt, 7);
        lit("frz_stall_count_a", a_cnt, 5);
        next();

        // Memory timeout on dut_b (limit 3).
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem_busy = 1'b1;
            @(negedge reloj);
            lit("tmo_during_busy", b_tmo, (i >= 3) ? 1 : 0);
            next();
        end
        idle();
        @(negedge reloj);
        lit("tmo_sticky_b", b_tmo, 1);
        lit("tmo_long_limit_a", a_tmo, 0);
        next();

        // Reset in the middle of a load stall.
        load_use_on_rs();
        next();
        idle(); reset = 1'b1;
        @(negedge reloj);
        lit("rst_mid_enablePC", b_pc, 0);
        lit("rst_mid_enableEX", b_ex, 0);
        lit("rst_mid_resetIF", b_rif, 1);
        lit("rst_mid_resetID", b_rid, 1);
        next();
        reset = 1'b0;
        @(negedge reloj);
        lit("rst_after_enablePC", b_pc, 1);
        lit("rst_after_stall_count", b_cnt, 0);
        lit("rst_after_mem_timeout", b_tmo, 0);
        next();
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
